alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Sequential counterpart of the combinational pico_mips ALU: the responder
//  that consumes operand transactions and returns results over a valid/ready
//  handshake. ADD completes in one cycle. Q1.7 fractional MUL uses an
//  iterative shift-add datapath over WIDTH cycles. Sits between the operand
//  issue logic and the register write-back path.
// PARAMETERS
//  WIDTH  8  operand/result width, two's complement
//  FRAC   7  fractional bits; MUL result = product[FRAC+WIDTH-1:FRAC]
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  n_reset    in   1      reset, synchronous, active-low
//  in_valid   in   1      operand transaction offered
//  in_ready   out  1      unit can accept (IDLE only)
//  alu_ctrl   in   1      1 = ADD, 0 = MUL; sampled on accept
//  input1     in   WIDTH  signed operand A; sampled on accept
//  input2     in   WIDTH  signed operand B; sampled on accept
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream takes result
//  result     out  WIDTH  signed result; stable while out_valid=1
//  busy       out  1      1 in MUL or DONE
// BEHAVIOUR
//  - Reset: on a clk edge with n_reset=0 -> state IDLE, in_ready=1,
//    out_valid=0, busy=0, result=0, all datapath registers cleared.
//    Reset aborts any operation in progress; no result is emitted.
//  - Accept: edge T with in_valid & in_ready latches alu_ctrl, input1, input2.
//  - States: IDLE -> (accept, ADD) DONE; IDLE -> (accept, MUL) MUL;
//    MUL -> DONE after WIDTH iterations; DONE -> (out_ready) IDLE.
//  - ADD: result = (input1 + input2) mod 2^WIDTH. No saturation.
//    out_valid=1 from cycle T+1.
//  - MUL: latch |A|, |B| and sign = A[msb]^B[msb]. Run WIDTH iterations of
//    unsigned shift-add into a 2*WIDTH accumulator using a WIDTH-bit iteration
//    counter. Negate the accumulator if sign=1. result = acc[FRAC+WIDTH-1:FRAC]
//    (truncation, no rounding or saturation).
//    out_valid=1 from cycle T+WIDTH+1 (T+9 at default).
//  - |-2^(WIDTH-1)| must be held in a WIDTH-bit unsigned magnitude without loss.
//    Example: -128*-128 = 0x4000, giving result 0x80 (wraps, by design).
//  - Handshake: in_ready=1 only in IDLE; there is no accept in the same cycle
//    as the DONE->IDLE transfer.
//    Result register is loaded only on entry to DONE; it is unchanged elsewhere.
//  - Backpressure: DONE holds out_valid and result for any number of cycles
//    while out_ready=0.
//  - out_ready while out_valid=0 has no effect. in_valid while in_ready=0 is
//    ignored; the inputs are not sampled.
// TESTING
//  1 ADD 0x7F+0x01 -> out_valid at T+1, result 0x80; 0xFF+0x01 -> 0x00.
//  2 MUL 0x40*0x40 (0.5*0.5) -> out_valid exactly T+9, result 0x20;
//    MUL 0xC0*0x40 -> result 0xE0.
//  3 MUL 0x80*0x80 -> result 0x80;
//    MUL 0x80*0x01 -> result 0xFF (0xFF80[14:7]).
//  4 Hold out_ready=0 for 5 cycles after a MUL completes -> result/out_valid
//    stable, in_ready=0; pulse in_valid -> ignored.
//    out_ready=1 -> IDLE on the next edge.
//  5 n_reset=0 at T+4 of a MUL -> next edge out_valid=0, in_ready=1, result=0;
//    a new ADD after release completes normally.
//  6 1000 seeded-random vectors per op, out_ready randomly throttled ->
//    every result equals golden model (A+B)[7:0] or (A*B)[14:7].

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU responder: single-cycle ADD and iterative sign-magnitude
// shift-add Q1.(WIDTH-1) MUL, returned over a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 7
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alu_ctrl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   iter;
    logic               sign;

    logic               accept;
    logic               mul_last;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   add_sum;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] acc_signed;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (iter == WIDTH'(WIDTH - 1));

    // The most negative operand negates to itself, which read as unsigned is
    // exactly its magnitude, so a WIDTH-bit magnitude loses nothing.
    assign mag1    = input1[WIDTH-1] ? (~input1 + WIDTH'(1)) : input1;
    assign mag2    = input2[WIDTH-1] ? (~input2 + WIDTH'(1)) : input2;
    assign add_sum = input1 + input2;

    assign acc_sum    = acc + (mplier[0] ? mcand : '0);
    assign acc_signed = sign ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = alu_ctrl ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared on reset, not just the FSM,
    // so an aborted multiply leaves no stale partial product behind.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            iter   <= '0;
            sign   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (alu_ctrl) begin
                            result <= add_sum;
                        end else begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, mag1};
                            mplier <= mag2;
                            iter   <= '0;
                            sign   <= input1[WIDTH-1] ^ input2[WIDTH-1];
                        end
                    end
                end
                S_MUL: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter + WIDTH'(1);
                    // Last partial product folds straight into the signed
                    // result so DONE is entered with the final value.
                    if (mul_last) begin
                        acc    <= acc_signed;
                        result <= acc_signed[FRAC+WIDTH-1:FRAC];
                    end else begin
                        acc    <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors with hand-computed results,
// latency/backpressure/reset checks, then throttled random traffic.
module tb_alu_seq;

    logic       clk;
    logic       n_reset;
    logic       in_valid;
    logic       in_ready;
    logic       alu_ctrl;
    logic [7:0] input1;
    logic [7:0] input2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         rand_throttle = 0;

    alu_seq #(.WIDTH(8), .FRAC(7)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic ctrl, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        logic [7:0]         s;
        s = a + b;
        p = $signed(a) * $signed(b);
        return ctrl ? s : p[14:7];
    endfunction

    // Monitor: a transfer happens at the next rising edge whenever both
    // out_valid and out_ready are high at the falling edge.
    always @(negedge clk) begin
        if (n_reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", result);
            end else begin
                check("result", {24'd0, result}, {24'd0, sb.pop_front()});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_throttle) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic ctrl, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            $display("FAIL in_ready_timeout: got in_ready=%0b expected 1", in_ready);
        end
        in_valid = 1'b1;
        alu_ctrl = ctrl;
        input1   = a;
        input2   = b;
        @(posedge clk);
        sb.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges from the accepting edge until out_valid is seen (1 = next cycle).
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [7:0] a, b;
        logic       op;

        void'($urandom(32'd20240611));
        n_reset   = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = 1'b0;
        input1    = 8'h00;
        input2    = 8'h00;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_result",    {24'd0, result},    32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // ADD: one-cycle latency, wrap without saturation
        issue(1'b1, 8'h7F, 8'h01, 8'h80);
        wait_out(lat);
        check("add_latency", lat, 1);
        issue(1'b1, 8'hFF, 8'h01, 8'h00);
        wait_out(lat);
        check("add_wrap_latency", lat, 1);

        // MUL: latency WIDTH+1, busy while iterating
        issue(1'b0, 8'h40, 8'h40, 8'h20);
        check("mul_busy",     {31'd0, busy},     32'd1);
        check("mul_in_ready", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("mul_latency", lat, 9);
        issue(1'b0, 8'hC0, 8'h40, 8'hE0);
        issue(1'b0, 8'h80, 8'h80, 8'h80);
        issue(1'b0, 8'h80, 8'h01, 8'hFF);
        issue(1'b0, 8'h01, 8'h80, 8'hFF);
        issue(1'b0, 8'h7F, 8'h7F, 8'h7E);

        // Backpressure: hold DONE, stray in_valid must be ignored
        issue(1'b1, 8'h00, 8'h00, 8'h00);
        wait_out(lat);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(1'b0, 8'hC0, 8'h40, 8'hE0);
        wait_out(lat);
        check("bp_latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            alu_ctrl = 1'b1;
            input1   = 8'h11;
            input2   = 8'h22;
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result",    {24'd0, result},    32'h0E0);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a MUL aborts it with no result
        issue(1'b0, 8'h40, 8'h40, 8'h20);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_result",    {24'd0, result},    32'd0);
        check("abort_busy",      {31'd0, busy},      32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_abort_idle", {31'd0, out_valid}, 32'd0);
        issue(1'b1, 8'h05, 8'h03, 8'h08);
        wait_out(lat);
        check("post_abort_add_latency", lat, 1);

        // Throttled random traffic against the golden model
        rand_throttle = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            op = 1'(i % 2);
            a  = 8'($urandom);
            b  = 8'($urandom);
            issue(op, a, b, model(op, a, b));
        end
        rand_throttle = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
